instr_encode_rv: RTL
====================

INSTR_ENCODE_RV -- requirements
Module: instr_encode_rv

Interface
REQ-001 SHALL have ports: iwClk  in  1  rising-edge clock.
REQ-002 SHALL have ports: iwnRst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: iwStart  in  1  one-cycle pulse that loads iwStartAddr, flushes the output register and enters RUN.
REQ-004 SHALL have ports: iwStartAddr  in  32  word address of the first emitted instruction; bits [1:0] are ignored and treated as 0.
REQ-005 SHALL have ports: iwInValid  in  1 / owInReady  out  1  input handshake.
REQ-006 SHALL have ports: iwClass  in  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP; 9-15 are illegal.
REQ-007 SHALL have ports: iwAluOp  in  4  `ALU_OP_* code; iwBranchInverted  in  1; iwDMemAccess  in  2  `MEM_ACCESS_*; iwDMemSignExtend  in  1.
REQ-008 SHALL have ports: iwRd, iwRs1, iwRs2  in  5 each; iwImm  in  32  signed byte offset or value (LUI/AUIPC: upper 20 bits used).
REQ-009 SHALL have ports: orOutValid  out  1 / iwOutReady  in  1  output handshake; orInstr  out  32  RV32I word; orAddr  out  32  address of orInstr.
REQ-010 SHALL have ports: orIllegal  out  1  sticky illegal flag; orCount  out  16  number of words emitted since the last start; orState  out  2  current state.

Function
REQ-011 SHALL implement the states IDLE(0), RUN(1) and HALT(2); iwStart moves any state to RUN; an illegal accepted input moves RUN to HALT.
REQ-012 SHALL drive owInReady = (state==RUN) && (!orOutValid || iwOutReady).
REQ-013 SHALL register the encoded word one cycle after input acceptance (latency 1) and SHALL sustain 1 word/cycle when accepting input and completing an output handshake in the same cycle.
REQ-014 SHALL hold orInstr and orAddr stable while orOutValid=1 and iwOutReady=0.
REQ-015 SHALL set orAddr to iwStartAddr on iwStart and add 4 on each output handshake, wrapping modulo 2^32; orCount SHALL add 1 per handshake and saturate at 0xFFFF.
REQ-016 SHALL use standard RV32I U/J/I/B/S/R formats with opcodes 37/17/6F/67/03/23/13/33/63 (hex).
REQ-017 SHALL map BRANCH as EQ->BEQ/BNE, SLT->BLT/BGE, SLTU->BLTU/BGEU, selecting the second form when iwBranchInverted=1; any other ALU op is illegal.
REQ-018 SHALL map LOAD funct3 from access and sign-extend as: byte->LB/LBU, half->LH/LHU, signed word->LW; an unsigned word is illegal.
REQ-019 SHALL map STORE as SB/SH/SW.
REQ-020 SHALL encode OP with all ten R-type ALU ops.
REQ-021 SHALL encode OP_IMM with ADD/SLT/SLTU/XOR/OR/AND and with SLL/SRL/SRA using shamt iwImm[4:0] (SRAI funct7=0100000); SUB is illegal for OP_IMM.
REQ-022 SHALL encode JALR with funct3=000.
REQ-023 SHALL, on an illegal input, accept the input, emit no word, set orIllegal, and enter HALT, where owInReady=0 and a pending output still drains.
REQ-024 SHALL give iwStart priority over a simultaneous input or output handshake; the pending word is discarded and orIllegal and orCount are cleared.

Reset
REQ-025 SHALL, while iwnRst=0 and independent of iwClk, force state=IDLE, orOutValid=0, orInstr=0, orAddr=0, orIllegal=0 and orCount=0; owInReady SHALL be 0.
REQ-026 SHALL, on a mid-transfer reset, lose the pending word; after reset release the block SHALL stay in IDLE until iwStart.

Configuration
REQ-027 SHALL, with INSTR_ENCODE_RV_RANGE_CHECK_EN defined, treat the following as illegal:
- I/S immediate outside -2048..2047;
- B immediate outside +/-4096 or odd;
- J immediate outside +/-1 MiB or odd;
- shamt iwImm[31:5] not equal to 0;
- LUI/AUIPC iwImm[11:0] not equal to 0.
REQ-028 SHALL, with INSTR_ENCODE_RV_RANGE_CHECK_EN undefined, truncate these fields silently and emit the word; class and op legality checks SHALL remain active.

Verification
REQ-029 SHALL cover: start addr 0x100; OP_IMM ADD rd=1 rs1=0 imm=5 -> orInstr=0x00500093, orAddr=0x100, one cycle later.
REQ-030 SHALL cover: LUI rd=2 imm=0x12345000 -> 0x12345137; then BRANCH EQ inverted rs1=1 rs2=2 imm=8 -> 0x00209463 at orAddr=0x108.
REQ-031 SHALL cover: STORE word rs1=1 rs2=2 imm=4 -> 0x0020A223; with iwOutReady held 0 for 3 cycles, the word is stable and owInReady=0.
REQ-032 SHALL cover: OP_IMM ADD rd=1 imm=0x800 -> with the macro: orIllegal=1, state HALT, no output; without the macro: 0x80000093 emitted.
REQ-033 SHALL cover: iwClass=9 -> orIllegal=1 and HALT; then iwStart -> RUN with orIllegal=0 and orCount=0.
REQ-034 SHALL cover: 3 back-to-back inputs with iwOutReady=1 -> 3 consecutive valid cycles and orCount=3; iwnRst pulsed mid-stream -> all outputs zero immediately.

Source files
------------

// File: rtl/instr_encode_rv.sv
// RV32I instruction encoder: class/op/field bundle in, 32-bit word out.
// Optional macro INSTR_ENCODE_RV_RANGE_CHECK_EN flags out-of-range immediates.
module instr_encode_rv (
    input  logic        iwClk,
    input  logic        iwnRst,
    input  logic        iwStart,
    input  logic [31:0] iwStartAddr,
    input  logic        iwInValid,
    output logic        owInReady,
    input  logic [3:0]  iwClass,
    input  logic [3:0]  iwAluOp,
    input  logic        iwBranchInverted,
    input  logic [1:0]  iwDMemAccess,
    input  logic        iwDMemSignExtend,
    input  logic [4:0]  iwRd,
    input  logic [4:0]  iwRs1,
    input  logic [4:0]  iwRs2,
    input  logic [31:0] iwImm,
    output logic        orOutValid,
    input  logic        iwOutReady,
    output logic [31:0] orInstr,
    output logic [31:0] orAddr,
    output logic        orIllegal,
    output logic [15:0] orCount,
    output logic [1:0]  orState
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [3:0] CL_LUI    = 4'd0;
    localparam logic [3:0] CL_AUIPC  = 4'd1;
    localparam logic [3:0] CL_JAL    = 4'd2;
    localparam logic [3:0] CL_JALR   = 4'd3;
    localparam logic [3:0] CL_BRANCH = 4'd4;
    localparam logic [3:0] CL_LOAD   = 4'd5;
    localparam logic [3:0] CL_STORE  = 4'd6;
    localparam logic [3:0] CL_OP_IMM = 4'd7;
    localparam logic [3:0] CL_OP     = 4'd8;

    // ALU op codes; EQ exists only for branch compares
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic        illegal_q, illegal_d;
    logic [15:0] count_q, count_d;

    logic        in_fire, out_fire;
    logic [31:0] enc_word;
    logic        enc_bad;
    logic [2:0]  f3;
    logic        imm_i_ok, imm_b_ok, imm_j_ok, shamt_ok, imm_u_ok;

`ifdef INSTR_ENCODE_RV_RANGE_CHECK_EN
    assign imm_i_ok = (&iwImm[31:11]) | ~(|iwImm[31:11]);
    assign imm_b_ok = ((&iwImm[31:12]) | ~(|iwImm[31:12])) & ~iwImm[0];
    assign imm_j_ok = ((&iwImm[31:20]) | ~(|iwImm[31:20])) & ~iwImm[0];
    assign shamt_ok = ~(|iwImm[31:5]);
    assign imm_u_ok = ~(|iwImm[11:0]);
`else
    assign imm_i_ok = 1'b1;
    assign imm_b_ok = 1'b1;
    assign imm_j_ok = 1'b1;
    assign shamt_ok = 1'b1;
    assign imm_u_ok = 1'b1;
`endif

    assign owInReady = (state_q == ST_RUN) && (!out_valid_q || iwOutReady);
    assign in_fire   = iwInValid && owInReady;
    assign out_fire  = out_valid_q && iwOutReady;

    // Encode the presented bundle and decide whether it is legal
    always_comb begin
        enc_word = 32'd0;
        enc_bad  = 1'b0;
        f3       = 3'd0;
        case (iwClass)
            CL_LUI, CL_AUIPC: begin
                enc_word = {iwImm[31:12], iwRd,
                            (iwClass == CL_LUI) ? 7'h37 : 7'h17};
                enc_bad  = !imm_u_ok;
            end
            CL_JAL: begin
                enc_word = {iwImm[20], iwImm[10:1], iwImm[11],
                            iwImm[19:12], iwRd, 7'h6F};
                enc_bad  = !imm_j_ok;
            end
            CL_JALR: begin
                enc_word = {iwImm[11:0], iwRs1, 3'b000, iwRd, 7'h67};
                enc_bad  = !imm_i_ok;
            end
            CL_BRANCH: begin
                case (iwAluOp)
                    ALU_EQ:   f3 = {2'b00, iwBranchInverted};
                    ALU_SLT:  f3 = {2'b10, iwBranchInverted};
                    ALU_SLTU: f3 = {2'b11, iwBranchInverted};
                    default:  enc_bad = 1'b1;
                endcase
                enc_word = {iwImm[12], iwImm[10:5], iwRs2, iwRs1, f3,
                            iwImm[4:1], iwImm[11], 7'h63};
                if (!imm_b_ok) enc_bad = 1'b1;
            end
            CL_LOAD: begin
                case (iwDMemAccess)
                    MEM_BYTE: f3 = iwDMemSignExtend ? 3'b000 : 3'b100;
                    MEM_HALF: f3 = iwDMemSignExtend ? 3'b001 : 3'b101;
                    MEM_WORD: begin
                        f3      = 3'b010;
                        enc_bad = !iwDMemSignExtend;
                    end
                    default:  enc_bad = 1'b1;
                endcase
                enc_word = {iwImm[11:0], iwRs1, f3, iwRd, 7'h03};
                if (!imm_i_ok) enc_bad = 1'b1;
            end
            CL_STORE: begin
                case (iwDMemAccess)
                    MEM_BYTE: f3 = 3'b000;
                    MEM_HALF: f3 = 3'b001;
                    MEM_WORD: f3 = 3'b010;
                    default:  enc_bad = 1'b1;
                endcase
                enc_word = {iwImm[11:5], iwRs2, iwRs1, f3,
                            iwImm[4:0], 7'h23};
                if (!imm_i_ok) enc_bad = 1'b1;
            end
            CL_OP_IMM: begin
                enc_word = {iwImm[11:0], iwRs1, 3'b000, iwRd, 7'h13};
                enc_bad  = !imm_i_ok;
                case (iwAluOp)
                    ALU_ADD:  enc_word[14:12] = 3'b000;
                    ALU_SLT:  enc_word[14:12] = 3'b010;
                    ALU_SLTU: enc_word[14:12] = 3'b011;
                    ALU_XOR:  enc_word[14:12] = 3'b100;
                    ALU_OR:   enc_word[14:12] = 3'b110;
                    ALU_AND:  enc_word[14:12] = 3'b111;
                    ALU_SLL, ALU_SRL, ALU_SRA: begin
                        f3       = (iwAluOp == ALU_SLL) ? 3'b001 : 3'b101;
                        enc_word = {1'b0, iwAluOp == ALU_SRA, 5'b00000,
                                    iwImm[4:0], iwRs1, f3, iwRd, 7'h13};
                        enc_bad  = !shamt_ok;
                    end
                    default:  enc_bad = 1'b1;
                endcase
            end
            CL_OP: begin
                case (iwAluOp)
                    ALU_ADD:  f3 = 3'b000;
                    ALU_SUB:  f3 = 3'b000;
                    ALU_SLL:  f3 = 3'b001;
                    ALU_SLT:  f3 = 3'b010;
                    ALU_SLTU: f3 = 3'b011;
                    ALU_XOR:  f3 = 3'b100;
                    ALU_SRL:  f3 = 3'b101;
                    ALU_SRA:  f3 = 3'b101;
                    ALU_OR:   f3 = 3'b110;
                    ALU_AND:  f3 = 3'b111;
                    default:  enc_bad = 1'b1;
                endcase
                enc_word = {1'b0,
                            (iwAluOp == ALU_SUB) || (iwAluOp == ALU_SRA),
                            5'b00000, iwRs2, iwRs1, f3, iwRd, 7'h33};
            end
            default: enc_bad = 1'b1;
        endcase
    end

    // Next-state: start flushes everything; otherwise drain then load
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        illegal_d   = illegal_q;
        count_d     = count_q;
        if (iwStart) begin
            state_d     = ST_RUN;
            out_valid_d = 1'b0;
            instr_d     = 32'd0;
            addr_d      = {iwStartAddr[31:2], 2'b00};
            illegal_d   = 1'b0;
            count_d     = 16'd0;
        end else begin
            if (out_fire) begin
                out_valid_d = 1'b0;
                addr_d      = addr_q + 32'd4;
                count_d     = (count_q == 16'hFFFF) ? count_q
                                                    : count_q + 16'd1;
            end
            if (in_fire) begin
                if (enc_bad) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    out_valid_d = 1'b1;
                    instr_d     = enc_word;
                end
            end
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            instr_q     <= 32'd0;
            addr_q      <= 32'd0;
            illegal_q   <= 1'b0;
            count_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            illegal_q   <= illegal_d;
            count_q     <= count_d;
        end
    end

    assign orOutValid = out_valid_q;
    assign orInstr    = instr_q;
    assign orAddr     = addr_q;
    assign orIllegal  = illegal_q;
    assign orCount    = count_q;
    assign orState    = state_q;

endmodule
